// File: rtl/fixed_point_complex_multiplier_if.sv
// Operand/result bundle for the fixed-point complex multiplier.
// The master side issues start and the operands; the slave side returns
// busy, done and the saturated product.
interface fixed_point_complex_multiplier_if #(
    parameter int WIDTH = 16
);
    logic                    start;
    logic signed [WIDTH-1:0] a_re;
    logic signed [WIDTH-1:0] a_im;
    logic signed [WIDTH-1:0] b_re;
    logic signed [WIDTH-1:0] b_im;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] p_re;
    logic signed [WIDTH-1:0] p_im;
    logic                    overflow;

    modport master (
        output start, a_re, a_im, b_re, b_im,
        input  busy, done, p_re, p_im, overflow
    );

    modport slave (
        input  start, a_re, a_im, b_re, b_im,
        output busy, done, p_re, p_im, overflow
    );
endinterface

// File: rtl/fixed_point_complex_multiplier.sv
// Fixed-point complex multiplier P = A*B.
// A single signed WIDTHxWIDTH multiplier is reused over four cycles
// (M0..M3). The wide accumulators are then rounded, shifted and saturated
// in NORM. Each result takes six cycles from the accepting edge through
// the done pulse.
module fixed_point_complex_multiplier #(
    parameter int WIDTH             = 16,
    parameter int EXP_WIDTH_A       = 15,
    parameter int EXP_WIDTH_B       = 5,
    parameter int EXP_WIDTH_PRODUCT = 5,
    parameter int ROUND             = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    fixed_point_complex_multiplier_if.slave bus
);
    localparam int SHIFT = EXP_WIDTH_A + EXP_WIDTH_B - EXP_WIDTH_PRODUCT;
    localparam int ACC_W = 2 * WIDTH + 1;

    // One spare bit above the accumulator so the rounding increment cannot wrap.
    localparam logic signed [ACC_W:0] RND_INC =
        (ROUND != 0 && SHIFT > 0) ? ((ACC_W + 1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0))
                                  : (ACC_W + 1)'(0);
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W - WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W - WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M0   = 3'd1,
        S_M1   = 3'd2,
        S_M2   = 3'd3,
        S_M3   = 3'd4,
        S_NORM = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
    logic signed [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic signed [WIDTH-1:0] p_re_q, p_re_d, p_im_q, p_im_d;
    logic                    ovf_q, ovf_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    logic signed [WIDTH-1:0]   mul_x_s, mul_y_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic signed [ACC_W-1:0]   prod_ext_s;
    logic        [WIDTH:0]     norm_re_s, norm_im_s;

    // Round, arithmetic-shift and saturate one accumulator; returns {overflow, value}.
    function automatic logic [WIDTH:0] normalize(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] r;
        r = {acc[ACC_W-1], acc} + RND_INC;
        r = r >>> SHIFT;
        if (r > SAT_MAX) begin
            normalize = {1'b1, SAT_MAX[WIDTH-1:0]};
        end else if (r < SAT_MIN) begin
            normalize = {1'b1, SAT_MIN[WIDTH-1:0]};
        end else begin
            normalize = {1'b0, r[WIDTH-1:0]};
        end
    endfunction

    // Select the operand pair feeding the shared multiplier in each product cycle.
    always_comb begin
        mul_x_s = ar_q;
        mul_y_s = br_q;
        case (state_q)
            S_M0:    begin mul_x_s = ar_q; mul_y_s = br_q; end
            S_M1:    begin mul_x_s = ai_q; mul_y_s = bi_q; end
            S_M2:    begin mul_x_s = ar_q; mul_y_s = bi_q; end
            S_M3:    begin mul_x_s = ai_q; mul_y_s = br_q; end
            default: begin mul_x_s = ar_q; mul_y_s = br_q; end
        endcase
    end

    assign prod_s     = mul_x_s * mul_y_s;
    assign prod_ext_s = {prod_s[2*WIDTH-1], prod_s};

    // Next-state, operand latch, accumulation and normalisation.
    always_comb begin
        state_d   = state_q;
        ar_d      = ar_q;
        ai_d      = ai_q;
        br_d      = br_q;
        bi_d      = bi_q;
        acc_re_d  = acc_re_q;
        acc_im_d  = acc_im_q;
        p_re_d    = p_re_q;
        p_im_d    = p_im_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        norm_re_s = normalize(acc_re_q);
        norm_im_s = normalize(acc_im_q);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ar_d     = bus.a_re;
                    ai_d     = bus.a_im;
                    br_d     = bus.b_re;
                    bi_d     = bus.b_im;
                    acc_re_d = '0;
                    acc_im_d = '0;
                    state_d  = S_M0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_M0: begin
                acc_re_d = acc_re_q + prod_ext_s;
                state_d  = S_M1;
            end
            S_M1: begin
                acc_re_d = acc_re_q - prod_ext_s;
                state_d  = S_M2;
            end
            S_M2: begin
                acc_im_d = acc_im_q + prod_ext_s;
                state_d  = S_M3;
            end
            S_M3: begin
                acc_im_d = acc_im_q + prod_ext_s;
                state_d  = S_NORM;
            end
            S_NORM: begin
                p_re_d  = norm_re_s[WIDTH-1:0];
                p_im_d  = norm_im_s[WIDTH-1:0];
                ovf_d   = norm_re_s[WIDTH] | norm_im_s[WIDTH];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ar_q     <= '0;
            ai_q     <= '0;
            br_q     <= '0;
            bi_q     <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            p_re_q   <= '0;
            p_im_q   <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ar_q     <= ar_d;
            ai_q     <= ai_d;
            br_q     <= br_d;
            bi_q     <= bi_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            p_re_q   <= p_re_d;
            p_im_q   <= p_im_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.p_re     = p_re_q;
    assign bus.p_im     = p_im_q;
    assign bus.overflow = ovf_q;
endmodule

// File: doc/fixed_point_complex_multiplier.md
FIXED_POINT_COMPLEX_MULTIPLIER -- requirements
Module: fixed_point_complex_multiplier

Interface
REQ-001 Parameter WIDTH, default 16: bit width of every operand and result component, two's complement.
REQ-002 Parameter EXP_WIDTH_A, default 15: fractional bits of A components (Q1.15 twiddle sin/cos).
REQ-003 Parameter EXP_WIDTH_B, default 5: fractional bits of B components (sample data).
REQ-004 Parameter EXP_WIDTH_PRODUCT, default 5: fractional bits of P components; EXP_WIDTH_A+EXP_WIDTH_B-EXP_WIDTH_PRODUCT SHALL be >= 0 (SHIFT).
REQ-005 Parameter ROUND, default 1: 1 = round half up before shift, 0 = truncate (floor).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  request; operands sampled on an edge where start=1 and state is IDLE.
REQ-009 a_re, a_im  input  WIDTH each  operand A, signed, EXP_WIDTH_A fractional bits.
REQ-010 b_re, b_im  input  WIDTH each  operand B, signed, EXP_WIDTH_B fractional bits.
REQ-011 busy  output  1  high while a computation is in progress.
REQ-012 done  output  1  single-cycle pulse; p_re/p_im/overflow valid.
REQ-013 p_re, p_im  output  WIDTH each  result P = A*B, signed, EXP_WIDTH_PRODUCT fractional bits.
REQ-014 overflow  output  1  high if either component saturated in the latest result.

Function
REQ-015 Block SHALL compute p_re = a_re*b_re - a_im*b_im, p_im = a_re*b_im + a_im*b_re, using one shared WIDTHxWIDTH signed multiplier, time-multiplexed.
REQ-016 FSM states SHALL be IDLE, M0, M1, M2, M3, NORM.
REQ-017 IDLE: on start=1, latch all four operands, clear both accumulators, go to M0; else stay.
REQ-018 M0..M3: one partial product per cycle, order ar*br (add to re), ai*bi (subtract from re), ar*bi (add to im), ai*br (add to im); M3 -> NORM.
REQ-019 Accumulators SHALL be 2*WIDTH+1 bits; no intermediate overflow.
REQ-020 NORM: per component, add 2^(SHIFT-1) if ROUND=1 and SHIFT>0, arithmetic right shift by SHIFT, saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; register p_re, p_im, overflow; assert done next cycle; go to IDLE.
REQ-021 Latency: done SHALL be high exactly 6 cycles after the edge sampling start (start edge + M0..M3 + NORM edges).
REQ-022 busy SHALL be high in M0..M3 and NORM, low in IDLE.
REQ-023 start while busy=1 SHALL be ignored; operand changes while busy SHALL not affect the result.
REQ-024 start high in the done cycle SHALL be accepted (back-to-back throughput one result per 6 cycles).
REQ-025 p_re, p_im, overflow SHALL hold their values until the next NORM update.
REQ-026 SHIFT=0: no rounding, saturation only.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE, busy=0, done=0, p_re=0, p_im=0, overflow=0, accumulators=0, from any state.
REQ-028 reset mid-operation SHALL abort the computation; no done pulse for it.
REQ-029 reset SHALL take priority over start on the same edge.

Verification
REQ-030 Basic: ROUND=1, a=(16384,0) [0.5], b=(96,-64) [3,-2] -> p=(48,-32) [1.5,-1], overflow=0, done 6 cycles after start.
REQ-031 Saturation: a=(32767,32767), b=(32767,32767) -> p_re=0, p_im=32767, overflow=1; then a=(16384,0), b=(96,-64) -> overflow=0.
REQ-032 Rounding: a=(1,0), b=(16384,0) -> p_re=1 with ROUND=1, 0 with ROUND=0; a=(-1,0), same b -> 0 with ROUND=1, -1 with ROUND=0.
REQ-033 Busy/back-to-back: start pulsed with new operands during M2 -> ignored, result unchanged; start held in done cycle -> second done exactly 6 cycles later.
REQ-034 Reset mid-op: reset during M2 -> next cycle busy=0, done=0, p_re=p_im=0, overflow=0; no done pulse follows.
REQ-035 Zero: a=(28672,0), b=(0,0) -> p=(0,0), overflow=0.
